usb_rx_stream: RTL and testbench

- Parametrised next-generation USB full-speed receiver front end: raw d_plus/d_minus in, validated PID plus payload bytes out.
- Payload bytes are delivered through an internal FIFO with a ready/valid handshake, so the downstream endpoint buffer may stall.
- Adds configurable oversampling, FIFO depth, maximum packet length, and explicit end-of-packet status reporting.
- Sits between the USB pads and the endpoint/AHB-Lite buffer logic.

---
 rtl/usb_rx_stream.sv | 388 ++++++++++++++++++++++++++++++++++++++
 tb/tb_usb_rx_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_stream.sv
// rtl/usb_rx_stream.sv - USB full-speed receiver: line sync, NRZI decode, unstuff, PID check, payload FIFO
// Optional CRC5/CRC16 residual check enabled by defining USB_RX_CRC_CHECK_EN.

module usb_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_ready,
    output logic [7:0] head_data,
    output logic       head_valid,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          push_ok;

    assign pop         = pop_ready && head_valid;
    assign push_ok     = push && ((count != CW'(DEPTH)) || pop);
    assign overflow    = push && (count == CW'(DEPTH)) && !pop;
    assign rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head register bypasses the array when the byte being written becomes the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_data  <= 8'h00;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (push_ok && (wr_ptr == rd_ptr_next)) begin
                head_data <= push_data;
            end else begin
                head_data <= mem[rd_ptr_next];
            end
        end
    end
endmodule

`ifdef USB_RX_CRC_CHECK_EN
module usb_rx_crc (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_en,
    input  logic bit_val,
    input  logic use_crc16,
    output logic crc_ok
);
    logic [4:0]  crc5;
    logic [15:0] crc16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc5  <= 5'h1F;
            crc16 <= 16'hFFFF;
        end else if (clear) begin
            crc5  <= 5'h1F;
            crc16 <= 16'hFFFF;
        end else if (bit_en) begin
            crc5  <= {crc5[3:0], 1'b0} ^ ((bit_val ^ crc5[4]) ? 5'h05 : 5'h00);
            crc16 <= {crc16[14:0], 1'b0} ^ ((bit_val ^ crc16[15]) ? 16'h8005 : 16'h0000);
        end
    end

    assign crc_ok = use_crc16 ? (crc16 == 16'h800D) : (crc5 == 5'h0C);
endmodule
`endif

module usb_rx_stream #(
    parameter int CLK_PER_BIT = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_BYTES   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           d_plus,
    input  logic                           d_minus,
    output logic [7:0]                     rx_data,
    output logic                           rx_data_valid,
    input  logic                           rx_data_ready,
    output logic [3:0]                     rx_pid,
    output logic                           rx_pid_valid,
    output logic                           rx_done,
    output logic [2:0]                     rx_status,
    output logic [$clog2(MAX_BYTES+1)-1:0] rx_byte_count
);
    localparam int HALF = CLK_PER_BIT / 2;
    localparam int TW   = $clog2(CLK_PER_BIT);
    localparam int BCW  = $clog2(MAX_BYTES + 1);

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_PID   = 3'd1;
    localparam logic [2:0] ST_STUFF = 3'd2;
    localparam logic [2:0] ST_LEN   = 3'd3;
    localparam logic [2:0] ST_OVF   = 3'd4;
    localparam logic [2:0] ST_CRC   = 3'd5;
    localparam logic [2:0] ST_EOP   = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERR} state_t;

    state_t         state;
    state_t         state_next;
    logic           dp_meta, dp_s, dp_prev, dm_meta, dm_s;
    logic [TW-1:0]  tmr;
    logic           dp_edge, smp, line_se0, line_j, nrzi_bit, k_start;
    logic           stuff_slot, bit_evt, stuff_err, byte_done, pid_good;
    logic [7:0]     byte_val;
    logic [6:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic [2:0]     ones_cnt;
    logic           prev_level;
    logic [2:0]     status_q;
    logic [BCW-1:0] byte_count;
    logic [2:0]     j_cnt;
    logic           se0_seen;
    logic           suppress;
    logic           push, err_set, done_evt, pid_accept, sync_start, sync_fail;
    logic [2:0]     err_code;
    logic           len_err, fifo_ovf, crc_fail;
    logic [2:0]     final_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta <= 1'b1;
            dp_s    <= 1'b1;
            dp_prev <= 1'b1;
            dm_meta <= 1'b0;
            dm_s    <= 1'b0;
            tmr     <= '0;
        end else begin
            dp_meta <= d_plus;
            dp_s    <= dp_meta;
            dp_prev <= dp_s;
            dm_meta <= d_minus;
            dm_s    <= dm_meta;
            if (dp_edge || (tmr == TW'(CLK_PER_BIT - 1))) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TW'(1);
            end
        end
    end

    assign dp_edge    = dp_s != dp_prev;
    assign smp        = !dp_edge && (tmr == TW'(HALF - 1));
    assign line_se0   = !dp_s && !dm_s;
    assign line_j     = dp_s && !dm_s;
    assign nrzi_bit   = dp_s == prev_level;
    assign k_start    = (state == S_IDLE) && dp_edge && !dp_s && dm_s;
    assign stuff_slot = (ones_cnt == 3'd6) && ((state == S_PID) || (state == S_DATA));
    assign bit_evt    = smp && !line_se0 && !stuff_slot &&
                        ((state == S_SYNC) || (state == S_PID) || (state == S_DATA));
    assign stuff_err  = smp && !line_se0 && stuff_slot && nrzi_bit;
    assign byte_done  = bit_evt && (bit_cnt == 3'd7);
    assign byte_val   = {nrzi_bit, shift_q};
    assign pid_good   = byte_val[7:4] == ~byte_val[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (k_start) state_next = S_SYNC;
            S_SYNC: if (smp) begin
                if (line_se0) state_next = S_ERR;
                else if (byte_done) state_next = (byte_val == 8'h80) ? S_PID : S_ERR;
            end
            S_PID: if (smp) begin
                if (line_se0) state_next = S_EOP;
                else if (stuff_err) state_next = S_ERR;
                else if (byte_done) state_next = pid_good ? S_DATA : S_ERR;
            end
            S_DATA: if (smp) begin
                if (line_se0) state_next = S_EOP;
                else if (stuff_err) state_next = S_ERR;
            end
            S_EOP: if (smp && !line_se0) state_next = line_j ? S_IDLE : S_ERR;
            S_ERR: if (smp && line_j && (se0_seen || (j_cnt == 3'd7))) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        err_set    = 1'b0;
        err_code   = ST_OK;
        done_evt   = 1'b0;
        pid_accept = 1'b0;
        sync_start = 1'b0;
        sync_fail  = 1'b0;
        case (state)
            S_IDLE: sync_start = k_start;
            S_SYNC: sync_fail = smp && (line_se0 || (byte_done && (byte_val != 8'h80)));
            S_PID: if (smp) begin
                if (line_se0) begin
                    err_set  = 1'b1;
                    err_code = ST_PID;
                end else if (stuff_err) begin
                    err_set  = 1'b1;
                    err_code = ST_STUFF;
                end else if (byte_done) begin
                    pid_accept = pid_good;
                    err_set    = !pid_good;
                    err_code   = ST_PID;
                end
            end
            S_DATA: if (smp) begin
                if (line_se0) begin
                    err_set  = (bit_cnt != 3'd0);
                    err_code = ST_EOP;
                end else if (stuff_err) begin
                    err_set  = 1'b1;
                    err_code = ST_STUFF;
                end else if (byte_done) begin
                    push = 1'b1;
                end
            end
            S_EOP: if (smp && !line_se0) begin
                done_evt = line_j;
                err_set  = !line_j;
                err_code = ST_EOP;
            end
            S_ERR: done_evt = smp && line_j && (se0_seen || (j_cnt == 3'd7));
            default: ;
        endcase
    end

    assign len_err      = push && (byte_count == BCW'(MAX_BYTES));
    assign final_status = (status_q != ST_OK) ? status_q : (crc_fail ? ST_CRC : ST_OK);

    usb_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push && !len_err),
        .push_data  (byte_val),
        .pop_ready  (rx_data_ready),
        .head_data  (rx_data),
        .head_valid (rx_data_valid),
        .overflow   (fifo_ovf)
    );

`ifdef USB_RX_CRC_CHECK_EN
    logic crc_en_q, crc16_q, crc_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_en_q <= 1'b0;
            crc16_q  <= 1'b0;
        end else if (sync_start) begin
            crc_en_q <= 1'b0;
            crc16_q  <= 1'b0;
        end else if (pid_accept) begin
            crc_en_q <= (byte_val[1:0] == 2'b01) || (byte_val[2:0] == 3'b011);
            crc16_q  <= byte_val[2:0] == 3'b011;
        end
    end

    usb_rx_crc u_crc (
        .clk       (clk),
        .rst       (rst),
        .clear     (sync_start),
        .bit_en    (bit_evt && (state == S_DATA)),
        .bit_val   (nrzi_bit),
        .use_crc16 (crc16_q),
        .crc_ok    (crc_ok)
    );

    assign crc_fail = crc_en_q && !crc_ok;
`else
    assign crc_fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q       <= '0;
            bit_cnt       <= '0;
            ones_cnt      <= '0;
            prev_level    <= 1'b1;
            status_q      <= ST_OK;
            byte_count    <= '0;
            j_cnt         <= '0;
            se0_seen      <= 1'b0;
            suppress      <= 1'b0;
            rx_pid        <= 4'h0;
            rx_pid_valid  <= 1'b0;
            rx_done       <= 1'b0;
            rx_status     <= ST_OK;
            rx_byte_count <= '0;
        end else begin
            rx_done <= done_evt && !suppress;
            if (done_evt && !suppress) begin
                rx_status     <= final_status;
                rx_byte_count <= byte_count;
            end
            if (state == S_IDLE) begin
                prev_level <= 1'b1;
            end else if (smp && !line_se0) begin
                prev_level <= dp_s;
            end
            if (sync_start) begin
                bit_cnt      <= '0;
                ones_cnt     <= '0;
                status_q     <= ST_OK;
                byte_count   <= '0;
                suppress     <= 1'b0;
                rx_pid_valid <= 1'b0;
            end
            // A stuffed slot consumes a line sample but never reaches the shifter.
            if (smp && !line_se0 && (state != S_IDLE) && (state != S_EOP) && (state != S_ERR)) begin
                if (stuff_slot) begin
                    ones_cnt <= '0;
                end else begin
                    ones_cnt <= nrzi_bit ? ((ones_cnt == 3'd6) ? 3'd6 : ones_cnt + 3'd1) : 3'd0;
                    shift_q  <= byte_val[7:1];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
            end
            if (sync_fail) begin
                suppress <= 1'b1;
            end
            if (pid_accept) begin
                rx_pid       <= byte_val[3:0];
                rx_pid_valid <= 1'b1;
            end
            if (push && (byte_count != BCW'(MAX_BYTES))) begin
                byte_count <= byte_count + BCW'(1);
            end
            if (status_q == ST_OK) begin
                if (err_set) status_q <= err_code;
                else if (len_err) status_q <= ST_LEN;
                else if (fifo_ovf) status_q <= ST_OVF;
            end
            if (state != S_ERR) begin
                j_cnt    <= '0;
                se0_seen <= 1'b0;
            end else if (smp) begin
                if (line_se0) begin
                    se0_seen <= 1'b1;
                    j_cnt    <= '0;
                end else if (line_j) begin
                    j_cnt <= j_cnt + 3'd1;
                end else begin
                    se0_seen <= 1'b0;
                    j_cnt    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_stream.sv
// tb/tb_usb_rx_stream.sv - directed bench for usb_rx_stream with a line-level USB packet encoder

module tb_usb_rx_stream;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [3:0] rx_pid;
    logic       rx_pid_valid;
    logic       rx_done;
    logic [2:0] rx_status;
    logic [6:0] rx_byte_count;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [2:0] last_status = '0;
    logic [6:0] last_count = '0;
    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic       cur_lvl;
    int         ones;
    int         prev_done;
    logic [7:0] head_snap;

    usb_rx_stream dut (
        .clk           (clk),
        .rst           (rst),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_pid        (rx_pid),
        .rx_pid_valid  (rx_pid_valid),
        .rx_done       (rx_done),
        .rx_status     (rx_status),
        .rx_byte_count (rx_byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt    = done_cnt + 1;
            last_status = rx_status;
            last_count  = rx_byte_count;
        end
        if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (!b) cur_lvl = !cur_lvl;
        d_plus  = cur_lvl;
        d_minus = !cur_lvl;
        hold(CPB);
    endtask

    task automatic send_body(input bit inject);
        bit injected = 0;
        cur_lvl = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        ones = 1;
        for (int k = 0; k < tx_q.size(); k++) begin
            for (int b = 0; b < 8; b++) begin
                send_bit(tx_q[k][b]);
                ones = tx_q[k][b] ? ones + 1 : 0;
                if (ones == 6) begin
                    if (inject && !injected) begin
                        send_bit(1'b1);
                        injected = 1;
                    end else begin
                        send_bit(1'b0);
                    end
                    ones = 0;
                end
            end
        end
    endtask

    task automatic send_eop();
        d_plus  = 1'b0;
        d_minus = 1'b0;
        hold(2 * CPB);
        d_plus  = 1'b1;
        d_minus = 1'b0;
        hold(6 * CPB);
    endtask

    task automatic append_crc16();
        logic [15:0] c = 16'hFFFF;
        logic [15:0] r;
        logic [7:0]  b0, b1;
        logic        fb;
        for (int i = 1; i < tx_q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = tx_q[i][b] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        r = ~c;
        for (int j = 0; j < 8; j++) begin
            b0[j] = r[15-j];
            b1[j] = r[7-j];
        end
        tx_q.push_back(b0);
        tx_q.push_back(b1);
    endtask

    task automatic wait_done(input string tag, input int prev);
        int n = 0;
        while (done_cnt == prev && n < 4000) begin
            @(posedge clk);
            n++;
        end
        hold(4 * CPB);
        chk(tag, done_cnt, prev + 1);
    endtask

    initial begin
        rst = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        hold(4);
        chk("reset_done", rx_done, 0);
        chk("reset_valid", rx_data_valid, 0);
        chk("reset_pid_valid", rx_pid_valid, 0);
        chk("reset_status", rx_status, 0);
        chk("reset_data", rx_data, 0);
        rst = 1'b0;
        hold(3 * CPB);

        tx_q = '{8'hD2};
        prev_done = done_cnt;
        send_body(0);
        send_eop();
        wait_done("ack_done", prev_done);
        chk("ack_status", last_status, 0);
        chk("ack_count", last_count, 0);
        chk("ack_pid", rx_pid, 4'h2);
        chk("ack_pid_valid", rx_pid_valid, 1);
        chk("ack_fifo_empty", rx_data_valid, 0);

        got_q.delete();
        tx_q = '{8'hC3, 8'h01, 8'h02, 8'h03};
        append_crc16();
        exp_q = tx_q[1:5];
        prev_done = done_cnt;
        send_body(0);
        send_eop();
        wait_done("data0_done", prev_done);
        chk("data0_status", last_status, 0);
        chk("data0_count", last_count, 5);
        chk("data0_pid", rx_pid, 4'h3);
        chk("data0_nbytes", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("data0_byte%0d", i), got_q[i], exp_q[i]);

        tx_q = '{8'hC3, 8'hFF};
        prev_done = done_cnt;
        send_body(1);
        send_eop();
        wait_done("stuff_done_once", prev_done);
        chk("stuff_status", last_status, 2);

        got_q.delete();
        tx_q = '{8'hC4};
        prev_done = done_cnt;
        send_body(0);
        send_eop();
        wait_done("piderr_done", prev_done);
        chk("piderr_status", last_status, 1);
        chk("piderr_pid_valid", rx_pid_valid, 0);
        chk("piderr_no_push", got_q.size(), 0);
        chk("piderr_fifo_empty", rx_data_valid, 0);

        rx_data_ready = 1'b0;
        tx_q = '{8'h4B, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        append_crc16();
        prev_done = done_cnt;
        send_body(0);
        send_eop();
        wait_done("ovf_done", prev_done);
        chk("ovf_status", last_status, 4);
        chk("ovf_count", last_count, 6);
        chk("ovf_head_valid", rx_data_valid, 1);
        head_snap = rx_data;
        hold(20);
        chk("ovf_head_stable", rx_data, head_snap);
        chk("ovf_head", rx_data, 8'hAA);
        rx_data_ready = 1'b1;
        hold(10);
        chk("ovf_nbytes", got_q.size(), 4);
        chk("ovf_byte0", got_q[0], 8'hAA);
        chk("ovf_byte1", got_q[1], 8'hBB);
        chk("ovf_byte2", got_q[2], 8'hCC);
        chk("ovf_byte3", got_q[3], 8'hDD);
        chk("ovf_drained", rx_data_valid, 0);

        tx_q = '{8'hC3, 8'h55, 8'h66, 8'h77};
        prev_done = done_cnt;
        send_body(0);
        rst = 1'b1;
        hold(3);
        chk("midrst_pid_valid", rx_pid_valid, 0);
        chk("midrst_valid", rx_data_valid, 0);
        chk("midrst_pid", rx_pid, 0);
        d_plus = 1'b1;
        d_minus = 1'b0;
        hold(4 * CPB);
        rst = 1'b0;
        hold(6 * CPB);
        chk("midrst_no_done", done_cnt, prev_done);
        tx_q = '{8'hD2};
        send_body(0);
        send_eop();
        wait_done("post_rst_done", prev_done);
        chk("post_rst_status", last_status, 0);
        chk("post_rst_pid", rx_pid, 4'h2);
        chk("post_rst_count", last_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
